// File: rtl/pix_frame_buf_pkg.sv
// Shared types and helpers for the pixel frame buffer.
package pix_frame_buf_pkg;

  // Write-side frame FSM states
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PASS = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  // SOF tag sits this many bits above the pixel MSB in a stored word
  localparam int SOF_TAG_OFS = 0;

  function automatic int sof_bit(input int data_w);
    return data_w + SOF_TAG_OFS;
  endfunction

  // Ceiling log2, used for pointer and level widths
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pfb_ram.sv
// Simple dual-port storage: one write port, registered read port.
module pfb_ram
  import pix_frame_buf_pkg::*;
#(
  parameter int W     = 17,
  parameter int DEPTH = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [W-1:0]              wdata,
  input  logic                      re,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [W-1:0]              rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Array write, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pix_frame_buf.sv
// Single-clock pixel frame buffer: frame-gated capture, SOF tagging,
// drop-or-stall overflow handling, level/drop/underflow reporting.
module pix_frame_buf
  import pix_frame_buf_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int DROP_MODE = 1,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic                         i_flush,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_data_vld,
  input  logic                         i_sof,
  output logic                         o_ready,
  input  logic                         i_rd_en,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_rd_sof,
  output logic                         o_rd_data_vld,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [clog2(DEPTH+1)-1:0]    o_level,
  output logic [CNT_W-1:0]             o_drop_cnt,
  output logic [CNT_W-1:0]             o_unf_cnt
);

  localparam int AW  = clog2(DEPTH);
  localparam int LW  = clog2(DEPTH+1);
  localparam int TAG = sof_bit(DATA_W);

  wr_state_e        st_q, st_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d, empty_q, empty_d, ready_q, ready_d;
  logic [CNT_W-1:0] drop_q, drop_d, unf_q, unf_d;
  logic             rd_vld_q, rd_vld_d;
  logic             wr_en, rd_en, ovf;
  logic [TAG:0]     wdata, rdata;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= WR_IDLE;
    else        st_q <= st_d;
  end

  // FSM next state; DROP re-evaluates as IDLE on the SOF that ends it
  always_comb begin
    st_d = st_q;
    if (i_flush) begin
      st_d = WR_IDLE;
    end else if (i_data_vld) begin
      case (st_q)
        WR_IDLE: if (wr_en) st_d = WR_PASS;
        WR_PASS: begin
          if (i_sof && !i_en) st_d = WR_IDLE;
          else if (ovf)       st_d = WR_DROP;
        end
        WR_DROP: if (i_sof) st_d = wr_en ? WR_PASS : WR_IDLE;
        default: st_d = WR_IDLE;
      endcase
    end
  end

  // FSM outputs: pixel write strobe and overflow event
  always_comb begin
    wr_en = 1'b0;
    ovf   = 1'b0;
    if (!i_flush && i_data_vld) begin
      case (st_q)
        WR_PASS: begin
          // a SOF with capture disabled ends the frame without storing
          if (!(i_sof && !i_en)) begin
            wr_en = !full_q;
            ovf   = full_q && (DROP_MODE != 0);
          end
        end
        // IDLE and DROP both only open a frame on an enabled SOF
        default: wr_en = i_sof && i_en && !full_q;
      endcase
    end
  end

  // Pointers, level, status flags and saturating counters
  always_comb begin
    rd_en    = i_rd_en && !empty_q;
    rd_vld_d = rd_en;
    wptr_d   = wptr_q + AW'(wr_en);
    rptr_d   = rptr_q + AW'(rd_en);
    level_d  = level_q + LW'(wr_en) - LW'(rd_en);
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    ready_d = (DROP_MODE != 0) ? 1'b1 : !full_d;
    drop_d  = drop_q;
    if (ovf && drop_q != '1) drop_d = drop_q + CNT_W'(1);
    unf_d   = unf_q;
    if (i_rd_en && empty_q && unf_q != '1) unf_d = unf_q + CNT_W'(1);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b1;
      drop_q   <= '0;
      unf_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ready_q  <= ready_d;
      drop_q   <= drop_d;
      unf_q    <= unf_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Stored word: pixel in the low bits, SOF tag above it
  always_comb begin
    wdata             = '0;
    wdata[DATA_W-1:0] = i_data;
    wdata[TAG]        = i_sof;
  end

  pfb_ram #(.W(TAG+1), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  assign o_rd_data     = rdata[DATA_W-1:0];
  assign o_rd_sof      = rdata[TAG];
  assign o_rd_data_vld = rd_vld_q;
  assign o_ready       = ready_q;
  assign o_empty       = empty_q;
  assign o_full        = full_q;
  assign o_level       = level_q;
  assign o_drop_cnt    = drop_q;
  assign o_unf_cnt     = unf_q;

endmodule
